// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing for the 1-to-4 TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned SLOT_W       = 2;
  localparam int unsigned SHADOW_LANES = NUM_LANES - 1;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1to4_dec.sv
// Slot index plus enable to one-hot lane write-enable; inverse of the 4-to-1 mux select.
module demux_1to4_dec
  import tdm_demux_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel,
  input  logic                 en,
  output logic [NUM_LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive-side TDM demultiplexer: sync-framed serial samples in, one parallel
// 4-lane word out per completed frame.
module tdm_demux_1to4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sync,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic                       out_valid,
  output logic [SLOT_W-1:0]          slot,
  output logic                       sync_err
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [SLOT_W-1:0]      slot_next;
  logic [SLOT_W-1:0]      wr_sel;
  logic                   wr_en;
  logic                   early_sync;
  logic [NUM_LANES-1:0]   lane_we;
  logic                   frame_done;
  logic [WIDTH-1:0]       shadow [SHADOW_LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HUNT:    if (in_valid && in_sync) state_next = COLLECT;
      COLLECT: if (in_valid && !in_sync && slot == LAST_SLOT) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // A sync sample always restarts at lane 0; an early sync also flags the abort.
  always_comb begin
    wr_en      = 1'b0;
    wr_sel     = '0;
    slot_next  = slot;
    early_sync = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        wr_en      = 1'b1;
        wr_sel     = '0;
        slot_next  = SLOT_W'(1);
        early_sync = (state == COLLECT);
      end else if (state == COLLECT) begin
        wr_en     = 1'b1;
        wr_sel    = slot;
        slot_next = slot + SLOT_W'(1);
      end
    end
  end

  demux_1to4_dec u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (lane_we)
  );

  // The last lane is never stored; its write-enable marks frame completion.
  assign frame_done = lane_we[NUM_LANES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      for (int k = 0; k < SHADOW_LANES; k++) shadow[k] <= '0;
    end else begin
      slot      <= slot_next;
      out_valid <= frame_done;
      sync_err  <= early_sync;
      for (int k = 0; k < SHADOW_LANES; k++) begin
        if (lane_we[k]) shadow[k] <= in_data;
      end
      if (frame_done) out_data <= {in_data, shadow[2], shadow[1], shadow[0]};
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4 with WIDTH=8.
module tb_tdm_demux_1to4;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_sync;
  logic [W-1:0]   in_data;
  logic [4*W-1:0] out_data;
  logic           out_valid;
  logic [1:0]     slot;
  logic           sync_err;

  int checks;
  int errors;
  int cycle;
  int sync_err_cnt;
  logic [4*W-1:0] exp_q [$];
  int             pulse_cycles [$];

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot      (slot),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: every out_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        pulse_cycles.push_back(cycle);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: out_data=%h with no frame expected", out_data);
        end else begin
          logic [4*W-1:0] exp;
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL frame_data: got %h expected %h", out_data, exp);
          end
        end
        checks++;
        if (sync_err !== 1'b0) begin
          errors++;
          $display("FAIL err_with_valid: sync_err=%b expected 0 during out_valid", sync_err);
        end
      end
      if (sync_err === 1'b1) sync_err_cnt++;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic s);
    in_valid = 1'b1;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sync = 1'b0;
    in_data = '0;
    #12;
    checks++;
    if ({out_data, out_valid, slot, sync_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: out_data=%h out_valid=%b slot=%0d sync_err=%b expected all 0",
               out_data, out_valid, slot, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [1:0] exp_slot [4];
    exp_slot[0] = 2'd1; exp_slot[1] = 2'd2; exp_slot[2] = 2'd3; exp_slot[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(32'hA3A2A1A0);
      send(W'(8'hA0 + i), i == 0);
      checks++;
      if (slot !== exp_slot[i]) begin
        errors++;
        $display("FAIL basic_slot%0d: slot=%0d expected %0d", i, slot, exp_slot[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse: out_valid=%b expected 1", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_gaps;
    int gaps [3];
    gaps[0] = 0; gaps[1] = 3; gaps[2] = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(32'hA3A2A1A0);
      send(W'(8'hA0 + i), i == 0);
      if (i < 3) begin
        idle(gaps[i]);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early_valid%0d: out_valid=%b expected 0", i, out_valid);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_no_sync;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    checks++;
    if (slot !== 2'd0) begin
      errors++;
      $display("FAIL nosync_slot: slot=%0d expected 0", slot);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(32'hB3B2B1B0);
      send(W'(8'hB0 + i), i == 0);
    end
    idle(1);
  endtask

  task automatic test_early_sync;
    int base_err;
    base_err = sync_err_cnt;
    send(8'hC0, 1'b1);
    send(8'hC1, 1'b0);
    send(8'hD0, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || slot !== 2'd1) begin
      errors++;
      $display("FAIL early_sync_flag: sync_err=%b slot=%0d expected 1/1", sync_err, slot);
    end
    checks++;
    if (out_data !== 32'hB3B2B1B0) begin
      errors++;
      $display("FAIL early_sync_hold: out_data=%h expected b3b2b1b0", out_data);
    end
    send(8'hD1, 1'b0);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL early_sync_width: sync_err=%b expected 0", sync_err);
    end
    send(8'hD2, 1'b0);
    exp_q.push_back(32'hD3D2D1D0);
    send(8'hD3, 1'b0);
    idle(1);
    checks++;
    if (sync_err_cnt - base_err !== 1) begin
      errors++;
      $display("FAIL early_sync_count: pulses=%0d expected 1", sync_err_cnt - base_err);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = pulse_cycles.size();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back(f == 0 ? 32'h43424140 : 32'h53525150);
        send(W'((f == 0 ? 8'h40 : 8'h50) + i), i == 0);
      end
    end
    idle(1);
    checks++;
    if (pulse_cycles.size() - n0 !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: count=%0d expected 2", pulse_cycles.size() - n0);
    end else begin
      checks++;
      if (pulse_cycles[n0+1] - pulse_cycles[n0] !== 4) begin
        errors++;
        $display("FAIL b2b_spacing: spacing=%0d expected 4",
                 pulse_cycles[n0+1] - pulse_cycles[n0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n0;
    n0 = pulse_cycles.size();
    send(8'hE0, 1'b1);
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, slot, sync_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: out_data=%h out_valid=%b slot=%0d sync_err=%b expected all 0",
               out_data, out_valid, slot, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'hE3, 1'b0);
    idle(2);
    checks++;
    if (pulse_cycles.size() !== n0 || slot !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_discard: pulses=%0d slot=%0d out_data=%h expected %0d/0/0",
               pulse_cycles.size(), slot, out_data, n0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle = 0;
    sync_err_cnt = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_no_sync();
    test_early_sync();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
